// File: rtl/trace_recorder.sv
// Instruction-trace buffer: records {pc, channels} on every PC change into a
// circular buffer with trigger, wrap/stop-when-full modes and FWFT readout.
module trace_recorder #(
    parameter int unsigned     DATA_W  = 32,
    parameter int unsigned     NCH     = 4,
    parameter int unsigned     DEPTH   = 16,
    parameter logic [DATA_W-1:0] INIT_PC = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic [NCH*DATA_W-1:0]      ch_in,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       trig_en,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic                       wrap_mode,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_pc,
    output logic [NCH*DATA_W-1:0]      rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic [15:0]                drop_cnt,
    output logic [1:0]                 state
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REC_W = NCH * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        drop_q, drop_d;
    logic [DATA_W-1:0]  pc_last_q, pc_last_d;

    logic [DATA_W-1:0]  pc_mem [DEPTH];
    logic [REC_W-1:0]   ch_mem [DEPTH];

    logic pc_event;
    logic is_empty;
    logic is_full;
    logic do_pop;
    logic wr_en;
    logic overwrite;
    logic cap_req;
    logic drop_inc;

    assign pc_event = (pc_in != pc_last_q);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        drop_d    = drop_q;
        pc_last_d = pc_in;
        do_pop    = 1'b0;
        wr_en     = 1'b0;
        overwrite = 1'b0;
        cap_req   = 1'b0;
        drop_inc  = 1'b0;

        if (arm) begin
            // arm wins over stop and discards any pending read
            state_d   = ST_ARMED;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            drop_d    = '0;
            pc_last_d = INIT_PC;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else begin
            do_pop = rd_ready && !is_empty;

            case (state_q)
                ST_ARMED: begin
                    if (pc_event && (!trig_en || (pc_in == trig_pc))) begin
                        cap_req = 1'b1;
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    cap_req = pc_event;
                end
                ST_DONE: begin
                    drop_inc = pc_event;
                    if (do_pop) begin
                        state_d = ST_CAPTURE;
                    end
                end
                default: ;
            endcase

            if (cap_req) begin
                if (is_full && !do_pop) begin
                    drop_inc = 1'b1;
                    if (wrap_mode) begin
                        wr_en     = 1'b1;
                        overwrite = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    wr_en = 1'b1;
                end
            end

            // A simultaneous pop and write keep count constant; overwrite
            // behaves like an implicit pop of the oldest record.
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop || overwrite) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(wr_en && !overwrite) - CNT_W'(do_pop);

            if (drop_inc && (drop_q != 16'hFFFF)) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            pc_last_q <= INIT_PC;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            pc_last_q <= pc_last_d;
        end
    end

    // Storage is cleared on reset only so waveforms start clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i] <= '0;
                ch_mem[i] <= '0;
            end
        end else if (wr_en) begin
            pc_mem[wr_ptr_q] <= pc_in;
            ch_mem[wr_ptr_q] <= ch_in;
        end
    end

    assign rd_valid = !is_empty;
    assign rd_pc    = pc_mem[rd_ptr_q];
    assign rd_data  = ch_mem[rd_ptr_q];
    assign count    = count_q;
    assign full     = is_full;
    assign drop_cnt = drop_q;
    assign state    = state_q;

endmodule

// File: tb/tb_trace_recorder.sv
// Directed bench for trace_recorder (DEPTH=4): capture, trigger, wrap,
// stop-when-full, full+pop, async reset and arm/stop priority.
module tb_trace_recorder;

    localparam int DATA_W = 32;
    localparam int NCH    = 4;
    localparam int DEPTH  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DATA_W-1:0]     pc_in;
    logic [NCH*DATA_W-1:0] ch_in;
    logic                  arm;
    logic                  stop;
    logic                  trig_en;
    logic [DATA_W-1:0]     trig_pc;
    logic                  wrap_mode;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_pc;
    logic [NCH*DATA_W-1:0] rd_data;
    logic                  rd_ready;
    logic [2:0]            count;
    logic                  full;
    logic [15:0]           drop_cnt;
    logic [1:0]            state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_recorder #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .DEPTH  (DEPTH),
        .INIT_PC(32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc_in),
        .ch_in    (ch_in),
        .arm      (arm),
        .stop     (stop),
        .trig_en  (trig_en),
        .trig_pc  (trig_pc),
        .wrap_mode(wrap_mode),
        .rd_valid (rd_valid),
        .rd_pc    (rd_pc),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .drop_cnt (drop_cnt),
        .state    (state)
    );

    function automatic logic [127:0] chv(input logic [31:0] p);
        return {p ^ 32'hA5A5_0000, p + 32'd1, ~p, {p[15:0], p[31:16]}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_pc(input logic [31:0] p);
        pc_in = p;
        ch_in = chv(p);
        step();
    endtask

    task automatic do_arm(input logic te, input logic [31:0] tp, input logic wm);
        trig_en   = te;
        trig_pc   = tp;
        wrap_mode = wm;
        arm       = 1'b1;
        step();
        arm       = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] p);
        chk({tag, "_pc"},   rd_pc,   p);
        chk({tag, "_data"}, rd_data, chv(p));
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pc_in = '0; ch_in = '0; arm = 1'b0; stop = 1'b0;
        trig_en = 1'b0; trig_pc = '0; wrap_mode = 1'b0; rd_ready = 1'b0;
        #2;
        chk("rst_state",    state,    2'd0);
        chk("rst_count",    count,    3'd0);
        chk("rst_full",     full,     1'b0);
        chk("rst_valid",    rd_valid, 1'b0);
        chk("rst_drop",     drop_cnt, 16'd0);
        step(); step();
        rst = 1'b1;
        put_pc(32'h40);
        chk("idle_ignore",  count,    3'd0);

        // basic capture with a repeated PC
        do_arm(1'b0, 32'h0, 1'b0);
        chk("arm_state",    state,    2'd1);
        chk("arm_valid",    rd_valid, 1'b0);
        put_pc(32'h0);
        chk("t1_first_cnt", count,    3'd1);
        chk("t1_first_st",  state,    2'd2);
        chk("t1_first_pc",  rd_pc,    32'h0);
        put_pc(32'h4); put_pc(32'h8); put_pc(32'h8); put_pc(32'hC);
        chk("t1_count",     count,    3'd4);
        chk("t1_full",      full,     1'b1);
        chk("t1_drop",      drop_cnt, 16'd0);
        pop_expect("t1_pop0", 32'h0);
        pop_expect("t1_pop1", 32'h4);
        pop_expect("t1_pop2", 32'h8);
        pop_expect("t1_pop3", 32'hC);
        chk("t1_empty",     rd_valid, 1'b0);

        // trigger on PC 0x10, stop-when-full
        do_arm(1'b1, 32'h10, 1'b0);
        put_pc(32'h0); put_pc(32'h4); put_pc(32'h8); put_pc(32'hC);
        chk("t2_armed",     state,    2'd1);
        chk("t2_armed_cnt", count,    3'd0);
        put_pc(32'h10);
        chk("t2_capture",   state,    2'd2);
        put_pc(32'h14); put_pc(32'h18); put_pc(32'h1C); put_pc(32'h20);
        chk("t2_done",      state,    2'd3);
        chk("t2_drop",      drop_cnt, 16'd1);
        pop_expect("t2_pop0", 32'h10);
        chk("t2_resume",    state,    2'd2);
        chk("t2_cnt",       count,    3'd3);

        // wrap mode: six PCs, oldest two overwritten
        do_arm(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) put_pc(32'h100 + 32'(4 * i));
        chk("t3_count",     count,    3'd4);
        chk("t3_full",      full,     1'b1);
        chk("t3_drop",      drop_cnt, 16'd2);
        chk("t3_state",     state,    2'd2);
        for (int i = 2; i < 6; i++) pop_expect($sformatf("t3_pop%0d", i), 32'h100 + 32'(4 * i));

        // stop-when-full: DONE after the fifth PC
        do_arm(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) put_pc(32'h200 + 32'(4 * i));
        chk("t4_cap",       state,    2'd2);
        put_pc(32'h210);
        chk("t4_done",      state,    2'd3);
        chk("t4_drop1",     drop_cnt, 16'd1);
        put_pc(32'h214);
        chk("t4_drop2",     drop_cnt, 16'd2);
        pop_expect("t4_pop0", 32'h200);
        chk("t4_resume",    state,    2'd2);
        for (int i = 1; i < 4; i++) pop_expect($sformatf("t4_pop%0d", i), 32'h200 + 32'(4 * i));

        // full buffer with event and pop in the same cycle
        do_arm(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) put_pc(32'h300 + 32'(4 * i));
        rd_ready = 1'b1;
        put_pc(32'h310);
        rd_ready = 1'b0;
        chk("t5_count",     count,    3'd4);
        chk("t5_drop",      drop_cnt, 16'd0);
        chk("t5_state",     state,    2'd2);
        for (int i = 1; i < 5; i++) pop_expect($sformatf("t5_pop%0d", i), 32'h300 + 32'(4 * i));

        // async reset mid-capture, then arm+stop together
        do_arm(1'b0, 32'h0, 1'b1);
        put_pc(32'h400); put_pc(32'h404); put_pc(32'h408);
        chk("t6_pre_cnt",   count,    3'd3);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_state", state,    2'd0);
        chk("t6_rst_count", count,    3'd0);
        chk("t6_rst_valid", rd_valid, 1'b0);
        chk("t6_rst_full",  full,     1'b0);
        chk("t6_rst_drop",  drop_cnt, 16'd0);
        chk("t6_rst_rdpc",  rd_pc,    32'h0);
        chk("t6_rst_data",  rd_data,  128'h0);
        put_pc(32'h40C);
        chk("t6_rst_hold",  count,    3'd0);
        rst  = 1'b1;
        stop = 1'b1;
        do_arm(1'b0, 32'h0, 1'b0);
        stop = 1'b0;
        chk("t6_armstop",   state,    2'd1);
        chk("t6_arm_cnt",   count,    3'd0);
        put_pc(32'h40C);
        chk("t6_post_cnt",  count,    3'd1);
        chk("t6_post_pc",   rd_pc,    32'h40C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
